// File: rtl/xor_csum_arbiter_if.sv
// Requester/result bundle for xor_csum_arbiter. Build with XOR_CSUM_LEN_EN
// to add the csum_len word-count output.
interface xor_csum_arbiter_if #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8,
    parameter int IDW   = 2
);
    logic [NREQ-1:0]       req_valid;
    logic [NREQ*WIDTH-1:0] req_data;
    logic [NREQ-1:0]       req_last;
    logic [NREQ-1:0]       req_ready;
    logic                  csum_valid;
    logic [WIDTH-1:0]      csum;
    logic [IDW-1:0]        csum_id;
    logic                  csum_ready;
`ifdef XOR_CSUM_LEN_EN
    logic [7:0]            csum_len;

    modport master (
        output req_valid, req_data, req_last, csum_ready,
        input  req_ready, csum_valid, csum, csum_id, csum_len
    );
    modport slave (
        input  req_valid, req_data, req_last, csum_ready,
        output req_ready, csum_valid, csum, csum_id, csum_len
    );
`else
    modport master (
        output req_valid, req_data, req_last, csum_ready,
        input  req_ready, csum_valid, csum, csum_id
    );
    modport slave (
        input  req_valid, req_data, req_last, csum_ready,
        output req_ready, csum_valid, csum, csum_id
    );
`endif
endinterface

// File: rtl/xor_csum_arbiter.sv
// Round-robin arbitrated XOR checksum engine; grant is locked per packet.
// Optional XOR_CSUM_LEN_EN adds a saturating 8-bit packet word count.
module xor_csum_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8,
    parameter int IDW   = 2
) (
    input  logic               clk,
    input  logic               reset,
    xor_csum_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           state_reg;
    logic [IDW-1:0]   gnt_reg;
    logic [IDW-1:0]   rr_ptr_reg;
    logic [IDW-1:0]   csum_id_reg;
    logic [WIDTH-1:0] acc_reg;
    logic [WIDTH-1:0] csum_reg;

    logic [WIDTH-1:0] word_data [NREQ];
    logic [NREQ-1:0]  ready_vec;
    logic             sel_valid;
    logic             sel_last;
    logic [WIDTH-1:0] sel_data;
    logic             pick_found;
    logic [IDW-1:0]   pick_idx;
    logic [IDW:0]     scan_sum;
    logic [IDW-1:0]   scan_idx;

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_req
            assign word_data[gi] = bus.req_data[gi*WIDTH +: WIDTH];
            assign ready_vec[gi] = (state_reg == BUSY) && (gnt_reg == IDW'(gi));
        end
    endgenerate

    assign sel_valid = bus.req_valid[gnt_reg];
    assign sel_last  = bus.req_last[gnt_reg];
    assign sel_data  = word_data[gnt_reg];

    // Scan downward so the smallest offset from rr_ptr is the last (winning) write.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        scan_sum   = '0;
        scan_idx   = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            scan_sum = {1'b0, rr_ptr_reg} + (IDW+1)'(k);
            if (scan_sum >= (IDW+1)'(NREQ)) begin
                scan_sum = scan_sum - (IDW+1)'(NREQ);
            end
            scan_idx = scan_sum[IDW-1:0];
            if (bus.req_valid[scan_idx]) begin
                pick_found = 1'b1;
                pick_idx   = scan_idx;
            end
        end
    end

`ifdef XOR_CSUM_LEN_EN
    logic [7:0] len_reg;
    logic [7:0] csum_len_reg;
    logic [7:0] len_next;

    assign len_next = (len_reg == 8'hFF) ? 8'hFF : len_reg + 8'd1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            len_reg      <= '0;
            csum_len_reg <= '0;
        end else if (state_reg == IDLE) begin
            len_reg <= '0;
        end else if (state_reg == BUSY && sel_valid) begin
            len_reg <= len_next;
            if (sel_last) begin
                csum_len_reg <= len_next;
            end
        end
    end

    assign bus.csum_len = csum_len_reg;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg   <= IDLE;
            gnt_reg     <= '0;
            rr_ptr_reg  <= '0;
            acc_reg     <= '0;
            csum_reg    <= '0;
            csum_id_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (pick_found) begin
                        gnt_reg   <= pick_idx;
                        acc_reg   <= '0;
                        state_reg <= BUSY;
                    end
                end
                BUSY: begin
                    if (sel_valid) begin
                        acc_reg <= acc_reg ^ sel_data;
                        if (sel_last) begin
                            csum_reg    <= acc_reg ^ sel_data;
                            csum_id_reg <= gnt_reg;
                            state_reg   <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (bus.csum_ready) begin
                        rr_ptr_reg <= (gnt_reg == IDW'(NREQ - 1)) ? '0 : gnt_reg + 1'b1;
                        state_reg  <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.req_ready  = ready_vec;
    assign bus.csum_valid = (state_reg == DONE);
    assign bus.csum       = csum_reg;
    assign bus.csum_id    = csum_id_reg;
endmodule

// File: tb/tb_xor_csum_arbiter.sv
// Directed bench for xor_csum_arbiter: per-requester word queues drive the
// inputs, a result scoreboard is checked on every csum handshake.
module tb_xor_csum_arbiter;
    localparam int NREQ  = 4;
    localparam int WIDTH = 8;
    localparam int IDW   = 2;

    typedef struct {
        logic [31:0] id;
        logic [31:0] csum;
        logic [31:0] len;
    } exp_t;

    logic clk = 1'b0;
    logic reset;

    xor_csum_arbiter_if #(.NREQ(NREQ), .WIDTH(WIDTH), .IDW(IDW)) bus ();

    xor_csum_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .IDW(IDW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    logic [WIDTH:0]  wq [NREQ][$];
    exp_t            sb [$];
    logic [NREQ-1:0] hold;
    logic [NREQ-1:0] forbid;
    int compared   = 0;
    int mismatched = 0;
    int cyc = 0;
    int vrun = 0;
    int last_vrun = 0;
    int hs_cyc = 0;
    int last_acc_cyc = 0;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send(int r, logic [WIDTH-1:0] d, logic last);
        wq[r].push_back({last, d});
    endtask

    task automatic expect_result(int id, logic [WIDTH-1:0] c, int len);
        exp_t e;
        e.id   = 32'(id);
        e.csum = 32'(c);
        e.len  = 32'(len);
        sb.push_back(e);
    endtask

    // One clock: drive at negedge, sample outputs, advance queues on accepted words.
    task automatic step();
        logic [NREQ-1:0] rdy;
        exp_t e;
        cyc++;
        for (int i = 0; i < NREQ; i++) begin
            if (wq[i].size() > 0 && !hold[i]) begin
                bus.req_valid[i] = 1'b1;
                bus.req_data[i*WIDTH +: WIDTH] = wq[i][0][WIDTH-1:0];
                bus.req_last[i] = wq[i][0][WIDTH];
            end else begin
                bus.req_valid[i] = 1'b0;
                bus.req_data[i*WIDTH +: WIDTH] = '0;
                bus.req_last[i] = 1'b0;
            end
        end
        rdy = bus.req_ready;
        chk("ready_onehot0", 32'($onehot0(rdy)), 32'd1);
        chk("ready_forbidden", 32'(rdy & forbid), 32'd0);
        if (bus.csum_valid) vrun++;
        if (bus.csum_valid && bus.csum_ready) begin
            chk("result_expected", 32'(sb.size() > 0), 32'd1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("csum", 32'(bus.csum), e.csum);
                chk("csum_id", 32'(bus.csum_id), e.id);
`ifdef XOR_CSUM_LEN_EN
                chk("csum_len", 32'(bus.csum_len), e.len);
`endif
                $display("result: id=%0d csum=0x%02h", bus.csum_id, bus.csum);
            end
            last_vrun = vrun;
            vrun = 0;
            hs_cyc = cyc;
            forbid = '0;
        end
        @(posedge clk);
        for (int i = 0; i < NREQ; i++) begin
            if (rdy[i] && bus.req_valid[i] && wq[i].size() > 0) begin
                if (wq[i][0][WIDTH]) last_acc_cyc = cyc;
                void'(wq[i].pop_front());
            end
        end
        @(negedge clk);
    endtask

    task automatic drain(int max);
        int n;
        n = 0;
        while (sb.size() > 0 && n < max) begin
            step();
            n++;
        end
        chk("drain_pending", 32'(sb.size()), 32'd0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        for (int i = 0; i < NREQ; i++) wq[i].delete();
        hold = '0;
        forbid = '0;
        vrun = 0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        int n;
        logic [WIDTH-1:0] x;
        reset = 1'b1;
        bus.req_valid  = '0;
        bus.req_data   = '0;
        bus.req_last   = '0;
        bus.csum_ready = 1'b1;
        hold = '0;
        forbid = '0;
        @(negedge clk);
        chk("rst_csum_valid", 32'(bus.csum_valid), 32'd0);
        chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
        chk("rst_csum", 32'(bus.csum), 32'd0);
        chk("rst_csum_id", 32'(bus.csum_id), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Two-word packet from requester 0.
        send(0, 8'h5A, 1'b0);
        send(0, 8'h3C, 1'b1);
        expect_result(0, 8'h66, 2);
        drain(50);
        chk("valid_cycles", 32'(last_vrun), 32'd1);
        chk("hs_after_last", 32'(hs_cyc - last_acc_cyc), 32'd1);
        chk("idle_ready", 32'(bus.req_ready), 32'd0);
        chk("idle_valid", 32'(bus.csum_valid), 32'd0);

        // All requesters busy: round-robin order 0,1,2,3,0.
        do_reset();
        send(0, 8'h01, 1'b1);
        send(0, 8'h01, 1'b1);
        send(1, 8'h02, 1'b1);
        send(2, 8'h04, 1'b1);
        send(3, 8'h08, 1'b1);
        expect_result(0, 8'h01, 1);
        expect_result(1, 8'h02, 1);
        expect_result(2, 8'h04, 1);
        expect_result(3, 8'h08, 1);
        expect_result(0, 8'h01, 1);
        drain(100);

        // Requester 1 with a 2-cycle gap; requester 2 must wait.
        do_reset();
        send(1, 8'hFF, 1'b0);
        send(1, 8'hFF, 1'b0);
        send(1, 8'h0F, 1'b1);
        send(2, 8'h33, 1'b1);
        expect_result(1, 8'h0F, 3);
        expect_result(2, 8'h33, 1);
        forbid = 4'b0100;
        step();
        step();
        hold[1] = 1'b1;
        step();
        step();
        chk("gap_words_left", 32'(wq[1].size()), 32'd2);
        hold[1] = 1'b0;
        drain(50);

        // Consumer stalls 10 cycles in DONE.
        bus.csum_ready = 1'b0;
        send(0, 8'h77, 1'b1);
        send(1, 8'h12, 1'b1);
        expect_result(0, 8'h77, 1);
        expect_result(1, 8'h12, 1);
        n = 0;
        while (!bus.csum_valid && n < 20) begin
            step();
            n++;
        end
        chk("done_reached", 32'(bus.csum_valid), 32'd1);
        for (int i = 0; i < 10; i++) begin
            step();
            chk("stall_csum", 32'(bus.csum), 32'h77);
            chk("stall_id", 32'(bus.csum_id), 32'd0);
            chk("stall_ready", 32'(bus.req_ready), 32'd0);
            chk("stall_valid", 32'(bus.csum_valid), 32'd1);
        end
        bus.csum_ready = 1'b1;
        step();
        chk("hs_on_ready_rise", 32'(hs_cyc), 32'(cyc));
        drain(50);

        // Reset mid-packet from requester 3.
        send(3, 8'h11, 1'b0);
        send(3, 8'h22, 1'b0);
        send(3, 8'h33, 1'b0);
        send(3, 8'h44, 1'b1);
        n = 0;
        while (wq[3].size() > 2 && n < 20) begin
            step();
            n++;
        end
        chk("two_accepted", 32'(wq[3].size()), 32'd2);
        reset = 1'b1;
        #1;
        chk("mid_rst_valid", 32'(bus.csum_valid), 32'd0);
        chk("mid_rst_ready", 32'(bus.req_ready), 32'd0);
        chk("mid_rst_csum", 32'(bus.csum), 32'd0);
        chk("mid_rst_id", 32'(bus.csum_id), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        wq[3].delete();
        send(3, 8'hA5, 1'b1);
        expect_result(3, 8'hA5, 1);
        drain(50);

`ifdef XOR_CSUM_LEN_EN
        // Word count saturation and a short packet.
        do_reset();
        x = '0;
        for (int i = 0; i < 300; i++) begin
            logic [WIDTH-1:0] d;
            d = WIDTH'($urandom_range(0, 255));
            x = x ^ d;
            send(0, d, (i == 299));
        end
        expect_result(0, x, 255);
        drain(400);
        x = '0;
        for (int i = 0; i < 5; i++) begin
            logic [WIDTH-1:0] d;
            d = WIDTH'($urandom_range(0, 255));
            x = x ^ d;
            send(2, d, (i == 4));
        end
        expect_result(2, x, 5);
        drain(50);
`else
        x = '0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
